// File: rtl/led_indicator_pkg.sv
// led_indicator_pkg: mode encodings and bus-slicing helper for the LED indicator engine
package led_indicator_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_OFF = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK_SLOW = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BLINK_FAST = 3'd3;
  localparam logic [MODE_W-1:0] MODE_PWM = 3'd4;
  localparam logic [MODE_W-1:0] MODE_FLASH = 3'd5;
  localparam logic [MODE_W-1:0] MODE_FLASH_INV = 3'd6;
  localparam logic [MODE_W-1:0] MODE_RSVD = 3'd7;
  function automatic int ch_lsb(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/led_stretch.sv
// led_stretch: retriggerable saturating tick-based pulse stretcher
module led_stretch #(
  parameter int STRETCH_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic evt,
  output logic active
);
  localparam int W = $clog2(STRETCH_TICKS + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (evt) cnt <= W'(STRETCH_TICKS);
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
  assign active = cnt != '0;
endmodule

// File: rtl/led_indicator.sv
// led_indicator: per-channel off/on/blink/PWM/flash drive for the RGB LED driver
module led_indicator
  import led_indicator_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 65536,
  parameter int BLINK_BITS = 8,
  parameter int STRETCH_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH*MODE_W-1:0]   mode,
  input  logic [NUM_CH*PWM_BITS-1:0] duty,
  input  logic [NUM_CH-1:0]          evt,
  output logic                       tick,
  output logic [NUM_CH-1:0]          led_pwm
);
  localparam int PRE_W = $clog2(PRESCALE);
  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [NUM_CH*PWM_BITS-1:0] duty_sh;
  logic [NUM_CH-1:0] active, c;
  always_ff @(posedge clk)
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      blink_cnt <= '0;
      duty_sh <= '0;
      tick <= 1'b0;
      led_pwm <= '0;
    end else begin
      pre_cnt <= pre_cnt == PRE_W'(PRESCALE - 1) ? '0 : pre_cnt + PRE_W'(1);
      tick <= pre_cnt == PRE_W'(PRESCALE - 1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      blink_cnt <= tick ? blink_cnt + BLINK_BITS'(1) : blink_cnt;
      duty_sh <= pwm_cnt == '1 ? duty : duty_sh;
      led_pwm <= c & {NUM_CH{enable}};
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [MODE_W-1:0] m;
    logic [PWM_BITS-1:0] d;
    assign m = mode[ch_lsb(i, MODE_W) +: MODE_W];
    assign d = duty_sh[ch_lsb(i, PWM_BITS) +: PWM_BITS];
    led_stretch #(.STRETCH_TICKS(STRETCH_TICKS)) u_st (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .evt(evt[i]),
      .active(active[i])
    );
    assign c[i] = m == MODE_ON ? 1'b1 :
                  m == MODE_BLINK_SLOW ? blink_cnt[BLINK_BITS-1] :
                  m == MODE_BLINK_FAST ? blink_cnt[BLINK_BITS-3] :
                  m == MODE_PWM ? pwm_cnt < d :
                  m == MODE_FLASH ? active[i] :
                  m == MODE_FLASH_INV ? ~active[i] : 1'b0;
  end
endmodule
